// File: rtl/ppu_pixel_fifo_mixer.sv
// PPU pixel FIFO: circular BG FIFO, 8-entry OBJ FIFO aligned to the BG head, fine-scroll discard,
// sprite/BG priority mixing and palette lookup. Optional OBJ path enabled by PPU_PXFIFO_OBJ_EN.
module ppu_pixel_fifo_mixer #(
    parameter int DEPTH  = 16,
    parameter int LINE_W = 160
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic [2:0] discard_i,
    input  logic       bg_load_valid_i,
    output logic       bg_load_ready_o,
    input  logic [7:0] bg_row_lo_i,
    input  logic [7:0] bg_row_hi_i,
    input  logic       obj_load_valid_i,
    input  logic [7:0] obj_row_lo_i,
    input  logic [7:0] obj_row_hi_i,
    input  logic       obj_pal_i,
    input  logic       obj_prio_i,
    input  logic       bg_en_i,
    input  logic [7:0] bgp_i,
    input  logic [7:0] obp0_i,
    input  logic [7:0] obp1_i,
    output logic       px_valid_o,
    input  logic       px_ready_i,
    output logic [1:0] px_out_o,
    output logic       line_done_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][1:0] bg_mem_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q, rd_next, wr_next;
    logic [CW-1:0]         bg_count_q, bg_count_d;
    logic [2:0]            disc_cnt_q;
    logic [7:0]            px_x_q;
    logic                  merge, pop_ok, load_fire, drop, vis_pop, shift;
    logic [1:0]            bg_head, bc, mix;

    assign bg_load_ready_o = (bg_count_q <= CW'(DEPTH - 8));
    assign load_fire       = bg_load_valid_i & bg_load_ready_o;
    assign pop_ok          = (bg_count_q != '0) & ~merge;
    assign drop            = pop_ok & (disc_cnt_q != 3'd0);
    assign px_valid_o      = pop_ok & (disc_cnt_q == 3'd0) & (px_x_q < 8'(LINE_W));
    assign vis_pop         = px_valid_o & px_ready_i;
    assign shift           = drop | vis_pop;
    assign line_done_o     = (px_x_q == 8'(LINE_W));

    assign rd_next    = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    // Rows always land on 8-aligned slots, so a row never straddles the wrap point.
    assign wr_next    = (wr_ptr_q == PW'(DEPTH - 8)) ? '0 : wr_ptr_q + PW'(8);
    assign bg_count_d = bg_count_q + (load_fire ? CW'(8) : '0) - (shift ? CW'(1) : '0);

    assign bg_head = bg_mem_q[rd_ptr_q];
    assign bc      = bg_en_i ? bg_head : 2'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bg_mem_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            bg_count_q <= '0;
            disc_cnt_q <= '0;
            px_x_q     <= '0;
        end else if (flush_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            bg_count_q <= '0;
            disc_cnt_q <= discard_i;
            px_x_q     <= '0;
        end else begin
            if (load_fire) begin
                for (int i = 0; i < 8; i++)
                    bg_mem_q[PW'(int'(wr_ptr_q) + i)] <= {bg_row_hi_i[7-i], bg_row_lo_i[7-i]};
                wr_ptr_q <= wr_next;
            end
            if (shift)   rd_ptr_q   <= rd_next;
            if (drop)    disc_cnt_q <= disc_cnt_q - 3'd1;
            if (vis_pop) px_x_q     <= px_x_q + 8'd1;
            bg_count_q <= bg_count_d;
        end
    end

`ifdef PPU_PXFIFO_OBJ_EN
    logic [7:0][1:0] obj_col_q;
    logic [7:0]      obj_pal_q, obj_prio_q;
    logic [1:0]      oc;

    assign merge = obj_load_valid_i;
    assign oc    = obj_col_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obj_col_q  <= '0;
            obj_pal_q  <= '0;
            obj_prio_q <= '0;
        end else if (flush_i) begin
            obj_col_q  <= '0;
            obj_pal_q  <= '0;
            obj_prio_q <= '0;
        end else if (merge) begin
            // Only transparent slots take the new sprite: earlier OAM index keeps priority.
            for (int i = 0; i < 8; i++) begin
                if (obj_col_q[i] == 2'd0) begin
                    obj_col_q[i]  <= {obj_row_hi_i[7-i], obj_row_lo_i[7-i]};
                    obj_pal_q[i]  <= obj_pal_i;
                    obj_prio_q[i] <= obj_prio_i;
                end
            end
        end else if (shift) begin
            for (int i = 0; i < 7; i++) begin
                obj_col_q[i]  <= obj_col_q[i+1];
                obj_pal_q[i]  <= obj_pal_q[i+1];
                obj_prio_q[i] <= obj_prio_q[i+1];
            end
            obj_col_q[7]  <= 2'd0;
            obj_pal_q[7]  <= 1'b0;
            obj_prio_q[7] <= 1'b0;
        end
    end

    always_comb begin
        mix = bgp_i[{bc, 1'b0} +: 2];
        if (oc != 2'd0 && (!obj_prio_q[0] || bc == 2'd0))
            mix = obj_pal_q[0] ? obp1_i[{oc, 1'b0} +: 2] : obp0_i[{oc, 1'b0} +: 2];
    end
`else
    logic unused_obj;
    assign unused_obj = ^{obj_load_valid_i, obj_row_lo_i, obj_row_hi_i, obj_pal_i, obj_prio_i,
                          obp0_i, obp1_i};
    assign merge      = 1'b0;
    assign mix        = bgp_i[{bc, 1'b0} +: 2];
`endif

    assign px_out_o = px_valid_o ? mix : 2'd0;

endmodule

// File: tb/tb_ppu_pixel_fifo_mixer.sv
// Bench for ppu_pixel_fifo_mixer: directed scenarios plus random traffic, checked every cycle
// against a queue-based pixel model; OBJ scenarios only when PPU_PXFIFO_OBJ_EN is defined.
module tb_ppu_pixel_fifo_mixer;
    localparam int DEPTH  = 16;
    localparam int LINE_W = 160;
`ifdef PPU_PXFIFO_OBJ_EN
    localparam bit OBJ_EN = 1'b1;
`else
    localparam bit OBJ_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic flush = 0, bg_load_valid = 0, obj_load_valid = 0, obj_pal = 0, obj_prio = 0;
    logic bg_en = 1, px_ready = 0;
    logic [2:0] discard = 0;
    logic [7:0] bg_row_lo = 0, bg_row_hi = 0, obj_row_lo = 0, obj_row_hi = 0;
    logic [7:0] bgp = 8'hE4, obp0 = 8'hE4, obp1 = 8'h1B;
    logic bg_load_ready, px_valid, line_done;
    logic [1:0] px_out;

    ppu_pixel_fifo_mixer #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .discard_i(discard),
        .bg_load_valid_i(bg_load_valid), .bg_load_ready_o(bg_load_ready),
        .bg_row_lo_i(bg_row_lo), .bg_row_hi_i(bg_row_hi),
        .obj_load_valid_i(obj_load_valid), .obj_row_lo_i(obj_row_lo), .obj_row_hi_i(obj_row_hi),
        .obj_pal_i(obj_pal), .obj_prio_i(obj_prio), .bg_en_i(bg_en),
        .bgp_i(bgp), .obp0_i(obp0), .obp1_i(obp1),
        .px_valid_o(px_valid), .px_ready_i(px_ready), .px_out_o(px_out), .line_done_o(line_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: BG pixels as a queue of colours, sprite slots as plain arrays.
    logic [1:0] bgq[$];
    logic [1:0] m_oc[8];
    logic       m_op[8], m_opr[8];
    int         m_disc, m_x;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bgq.delete();
        for (int i = 0; i < 8; i++) begin m_oc[i] = 0; m_op[i] = 0; m_opr[i] = 0; end
        m_disc = 0;
        m_x = 0;
    endtask

    task automatic obj_shift();
        for (int i = 0; i < 7; i++) begin m_oc[i] = m_oc[i+1]; m_op[i] = m_op[i+1]; m_opr[i] = m_opr[i+1]; end
        m_oc[7] = 0; m_op[7] = 0; m_opr[7] = 0;
    endtask

    // Called at posedge+1 with inputs applied: checks outputs, then advances model on the edge.
    task automatic cyc();
        logic mrg, pop_ok, ev, er, ed;
        logic [1:0] eo, oc, bc;
        logic [7:0] pal;
        #2;
        mrg    = OBJ_EN && obj_load_valid;
        pop_ok = (bgq.size() > 0) && !mrg;
        er     = (bgq.size() <= DEPTH - 8);
        ev     = pop_ok && m_disc == 0 && m_x < LINE_W;
        ed     = (m_x == LINE_W);
        oc     = OBJ_EN ? m_oc[0] : 2'd0;
        bc     = (bg_en && bgq.size() > 0) ? bgq[0] : 2'd0;
        if (oc != 0 && (!m_opr[0] || bc == 0)) begin
            pal = m_op[0] ? obp1 : obp0;
            pal = pal >> (2 * oc);
        end else begin
            pal = bgp >> (2 * bc);
        end
        eo = ev ? pal[1:0] : 2'd0;
        chk("px_valid", {7'd0, px_valid}, {7'd0, ev});
        chk("px_out", {6'd0, px_out}, {6'd0, eo});
        chk("bg_load_ready", {7'd0, bg_load_ready}, {7'd0, er});
        chk("line_done", {7'd0, line_done}, {7'd0, ed});
        @(posedge clk);
        if (flush) begin
            model_reset();
            m_disc = int'(discard);
        end else begin
            if (pop_ok && m_disc != 0) begin
                void'(bgq.pop_front()); m_disc--; obj_shift();
            end else if (ev && px_ready) begin
                void'(bgq.pop_front()); m_x++; obj_shift();
            end
            if (mrg)
                for (int i = 0; i < 8; i++)
                    if (m_oc[i] == 0) begin
                        m_oc[i] = {obj_row_hi[7-i], obj_row_lo[7-i]};
                        m_op[i] = obj_pal; m_opr[i] = obj_prio;
                    end
            if (bg_load_valid && er)
                for (int i = 0; i < 8; i++) bgq.push_back({bg_row_hi[7-i], bg_row_lo[7-i]});
        end
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, {7'd0, px_valid}, 8'd0);
        chk({tag, "_out"}, {6'd0, px_out}, 8'd0);
        chk({tag, "_ready"}, {7'd0, bg_load_ready}, 8'd1);
        chk({tag, "_done"}, {7'd0, line_done}, 8'd0);
    endtask

    task automatic do_flush(input logic [2:0] d);
        flush = 1; discard = d; cyc(); flush = 0;
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_outs("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // T1: single row, shades 1,1,1,1,2,2,2,2 then empty
        bgp = 8'hE4; bg_row_lo = 8'hF0; bg_row_hi = 8'h0F; bg_load_valid = 1;
        cyc();
        bg_load_valid = 0; px_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_shade", {6'd0, px_out}, (k < 4) ? 8'd1 : 8'd2);
            cyc();
        end
        #1;
        chk("t1_empty_valid", {7'd0, px_valid}, 8'd0);
        chk("t1_empty_ready", {7'd0, bg_load_ready}, 8'd1);
        cyc();

        // T2: discard 3 across two rows
        do_flush(3'd3);
        bg_load_valid = 1;
        bg_row_lo = 8'hA5; bg_row_hi = 8'h3C; cyc();
        bg_row_lo = 8'h0F; bg_row_hi = 8'hF0; cyc();
        bg_load_valid = 0;
        for (int k = 0; k < 20; k++) cyc();

        // T3: fill to DEPTH with no consumer, then pop+load at count 8
        do_flush(3'd0);
        px_ready = 0; bg_load_valid = 1;
        cyc(); cyc();
        bg_load_valid = 0; #1;
        chk("t3_full_ready", {7'd0, bg_load_ready}, 8'd0);
        cyc();
        px_ready = 1;
        for (int k = 0; k < 8; k++) cyc();
        bg_load_valid = 1; cyc();
        bg_load_valid = 0; px_ready = 0; #1;
        chk("t3_after_pop_load_ready", {7'd0, bg_load_ready}, 8'd0);
        cyc();
        px_ready = 1;
        for (int k = 0; k < 7; k++) cyc();
        #1;
        chk("t3_count8_ready", {7'd0, bg_load_ready}, 8'd1);
        cyc();

        // T6: full line then flush
        do_flush(3'd0);
        bg_load_valid = 1; px_ready = 1;
        for (int k = 0; k < 200; k++) begin
            bg_row_lo = 8'($urandom); bg_row_hi = 8'($urandom);
            cyc();
        end
        #1;
        chk("t6_line_done", {7'd0, line_done}, 8'd1);
        chk("t6_valid_low", {7'd0, px_valid}, 8'd0);
        cyc();
        bg_load_valid = 0;
        do_flush(3'd0);
        #1;
        chk("t6_flush_done", {7'd0, line_done}, 8'd0);
        chk("t6_flush_ready", {7'd0, bg_load_ready}, 8'd1);
        cyc();

`ifdef PPU_PXFIFO_OBJ_EN
        // T4: earlier sprite keeps its slots
        do_flush(3'd0);
        px_ready = 0; bg_en = 1; bgp = 8'hE4; obp0 = 8'hE4;
        bg_row_lo = 8'h00; bg_row_hi = 8'h00; bg_load_valid = 1; cyc();
        bg_load_valid = 0;
        obj_load_valid = 1; obj_pal = 0; obj_prio = 0;
        obj_row_lo = 8'hFF; obj_row_hi = 8'h00; cyc();
        obj_row_lo = 8'h00; obj_row_hi = 8'hFF; cyc();
        obj_load_valid = 0; #1;
        chk("t4_first_sprite", {6'd0, px_out}, 8'd1);
        cyc();

        // T5: priority bit vs BG colour 2, then bg_en=0
        do_flush(3'd0);
        bg_row_lo = 8'h00; bg_row_hi = 8'hFF; bg_load_valid = 1; cyc();
        bg_load_valid = 0;
        obj_load_valid = 1; obj_prio = 1; obj_row_lo = 8'hFF; obj_row_hi = 8'h00; cyc();
        obj_load_valid = 0; obj_prio = 0; #1;
        chk("t5_bg_wins", {6'd0, px_out}, 8'd2);
        cyc();
        bg_en = 0; #1;
        chk("t5_obj_wins", {6'd0, px_out}, 8'd1);
        cyc();
        bg_en = 1;
`endif

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            flush          = ($urandom_range(0, 299) == 0);
            discard        = 3'($urandom);
            bg_load_valid  = ($urandom_range(0, 1) == 1);
            bg_row_lo      = 8'($urandom); bg_row_hi = 8'($urandom);
            obj_load_valid = ($urandom_range(0, 7) == 0);
            obj_row_lo     = 8'($urandom); obj_row_hi = 8'($urandom);
            obj_pal        = 1'($urandom); obj_prio = 1'($urandom);
            bg_en          = ($urandom_range(0, 9) != 0);
            px_ready       = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) begin
                bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
            end
            cyc();
        end
        flush = 0; obj_load_valid = 0;

        // Async reset mid-line, then nothing emitted until a refill
        bg_load_valid = 1; px_ready = 1;
        for (int k = 0; k < 4; k++) cyc();
        rst_n = 0; #1;
        chk_reset_outs("midreset");
        model_reset();
        bg_load_valid = 0;
        #3 rst_n = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) cyc();
        bg_load_valid = 1; cyc();
        bg_load_valid = 0;
        for (int k = 0; k < 10; k++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
